// File: rtl/ahb_mtx_arb_rr_if.sv
// Bus-side signals of the round-robin output-stage arbiter.
// "master" drives the transfer-side inputs; "slave" is the arbiter itself.
interface ahb_mtx_arb_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
);
  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;
  logic                 arb_switch;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, arb_switch
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, arb_switch
  );
endinterface

// File: rtl/ahb_mtx_arb_rr.sv
// Round-robin output-stage arbiter for one slave port of the AHB matrix.
// Never breaks a fixed-length burst or a locked sequence; otherwise grants
// the next requesting port after the last one granted.
module ahb_mtx_arb_rr #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_mtx_arb_rr_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic [3:0]           count_q, next_count;
  logic                 hold_q, next_hold;
  logic [PORT_W-1:0]    ptr_q, port_next, rr_sel, idx_w;
  logic                 rr_hit, no_port_next, sw_next;
  logic [NUM_PORTS-1:0] cand;

  // Burst tracker: remaining beats of a fixed burst and the hold flag.
  always_comb begin
    next_count = count_q;
    next_hold  = hold_q;
    if (bus.HREADYM) begin
      if (!bus.HSELM) begin
        next_count = '0;
        next_hold  = 1'b0;
      end else begin
        case (bus.HTRANSM)
          NONSEQ: begin
            case (bus.HBURSTM)
              3'd2, 3'd3: begin next_count = 4'd3;  next_hold = 1'b1; end
              3'd4, 3'd5: begin next_count = 4'd7;  next_hold = 1'b1; end
              3'd6, 3'd7: begin next_count = 4'd15; next_hold = 1'b1; end
              default:    begin next_count = 4'd0;  next_hold = 1'b0; end
            endcase
          end
          SEQ: begin
            // Saturate at zero so a stray SEQ never re-arms a long hold.
            if (count_q != 4'd0) next_count = count_q - 4'd1;
            if (count_q == 4'd1) next_hold  = 1'b0;
          end
          BUSY:    ;
          default: begin next_count = '0; next_hold = 1'b0; end
        endcase
      end
    end
  end

  // Candidates: requesters plus the current owner while it is still active.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      cand[i] = bus.req_port[i] |
                ((PORT_W'(i) == bus.addr_in_port) & !bus.no_port &
                 bus.HSELM & (bus.HTRANSM != IDLE));
  end

  // Round-robin search from ptr+1; the ptr+1 candidate is assigned last and wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = bus.addr_in_port;
    idx_w  = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx_w = PORT_W'((int'(ptr_q) + k) % NUM_PORTS);
      if (cand[idx_w]) begin
        rr_hit = 1'b1;
        rr_sel = idx_w;
      end
    end
  end

  // Grant decision: lock and burst hold pin the owner; idle selects park.
  always_comb begin
    port_next    = bus.addr_in_port;
    no_port_next = bus.no_port;
    if (bus.HMASTLOCKM || next_hold) begin
      port_next    = bus.addr_in_port;
      no_port_next = bus.no_port;
    end else if (rr_hit) begin
      port_next    = rr_sel;
      no_port_next = 1'b0;
    end else if (bus.HSELM) begin
      no_port_next = 1'b0;
    end else begin
      no_port_next = 1'b1;
    end
    sw_next = bus.HREADYM &
              ((no_port_next != bus.no_port) |
               (!no_port_next & (port_next != bus.addr_in_port)));
  end

  // Burst tracker state; wait states hold via the next-state logic.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      count_q <= next_count;
      hold_q  <= next_hold;
    end
  end

  // Arbitration state only moves on completed transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.addr_in_port <= '0;
      bus.no_port      <= 1'b1;
      bus.arb_switch   <= 1'b0;
      ptr_q            <= PORT_W'(NUM_PORTS - 1);
    end else begin
      bus.arb_switch <= sw_next;
      if (bus.HREADYM) begin
        bus.addr_in_port <= port_next;
        bus.no_port      <= no_port_next;
        if (!no_port_next) ptr_q <= port_next;
      end
    end
  end
endmodule

// File: tb/tb_ahb_mtx_arb_rr.sv
// Scenario bench for the round-robin output-stage arbiter (4 ports).
module tb_ahb_mtx_arb_rr;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] INCR8  = 3'd5;

  typedef struct {
    logic [3:0] req;
    logic       rdy, sel;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       lk;
  } stim_t;
  typedef struct {
    logic [1:0] addr;
    logic       no, sw;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];

  ahb_mtx_arb_rr_if #(.NUM_PORTS(4), .PORT_W(2)) ifc ();
  ahb_mtx_arb_rr #(.NUM_PORTS(4), .PORT_W(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(ifc)
  );

  always #5 HCLK = ~HCLK;

  function automatic stim_t mk(input logic [3:0] req, input logic rdy, input logic sel,
                               input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    stim_t s;
    s.req = req; s.rdy = rdy; s.sel = sel; s.tr = tr; s.bu = bu; s.lk = lk;
    return s;
  endfunction

  function automatic exp_t ex(input int addr, input logic no, input logic sw);
    exp_t e;
    e.addr = 2'(addr); e.no = no; e.sw = sw;
    return e;
  endfunction

  // Apply one cycle of stimulus, queue its expected result, sample after the edge.
  task automatic drive(input stim_t s, input exp_t e);
    @(negedge HCLK);
    ifc.req_port   = s.req;
    ifc.HREADYM    = s.rdy;
    ifc.HSELM      = s.sel;
    ifc.HTRANSM    = s.tr;
    ifc.HBURSTM    = s.bu;
    ifc.HMASTLOCKM = s.lk;
    sb.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_idle();
    ifc.req_port = '0; ifc.HREADYM = 1'b1; ifc.HSELM = 1'b0;
    ifc.HTRANSM = IDLE; ifc.HBURSTM = SINGLE; ifc.HMASTLOCKM = 1'b0;
  endtask

  task automatic test_reset();
    exp_t g;
    set_idle();
    HRESETn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(ex(0, 1'b1, 1'b0));
      @(posedge HCLK); #1;
      g = sb.pop_front();
      tests++;
      if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
        failed++;
        $display("FAIL reset[%0d] got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b", k,
                 ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
      end
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_rr();
    stim_t s[$]; exp_t e[$]; exp_t g;
    for (int k = 0; k < 5; k++) begin
      s.push_back(mk(4'b1111, 1, 1, NONSEQ, SINGLE, 0));
      e.push_back(ex(k % 4, 1'b0, 1'b1));
    end
    for (int k = 0; k < s.size(); k++) begin
      drive(s[k], e[k]);
      g = sb.pop_front();
      tests++;
      if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
        failed++;
        $display("FAIL rr[%0d] got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b", k,
                 ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
      end
    end
  endtask

  task automatic test_burst();
    stim_t s[$]; exp_t e[$]; exp_t g;
    s.push_back(mk(4'b0010, 1, 1, NONSEQ, SINGLE, 0)); e.push_back(ex(1, 0, 1));
    s.push_back(mk(4'b1101, 1, 1, NONSEQ, INCR4, 0));  e.push_back(ex(1, 0, 0));
    s.push_back(mk(4'b1101, 1, 1, SEQ, INCR4, 0));     e.push_back(ex(1, 0, 0));
    s.push_back(mk(4'b1101, 1, 1, SEQ, INCR4, 0));     e.push_back(ex(1, 0, 0));
    s.push_back(mk(4'b1101, 1, 1, SEQ, INCR4, 0));     e.push_back(ex(2, 0, 1));
    for (int k = 0; k < s.size(); k++) begin
      drive(s[k], e[k]);
      g = sb.pop_front();
      tests++;
      if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
        failed++;
        $display("FAIL burst[%0d] got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b", k,
                 ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
      end
    end
  endtask

  task automatic test_lock();
    stim_t s[$]; exp_t e[$]; exp_t g;
    for (int k = 0; k < 6; k++) begin
      s.push_back(mk(4'b0011, 1, 1, NONSEQ, SINGLE, 1)); e.push_back(ex(2, 0, 0));
    end
    s.push_back(mk(4'b0011, 1, 1, NONSEQ, SINGLE, 0)); e.push_back(ex(0, 0, 1));
    for (int k = 0; k < s.size(); k++) begin
      drive(s[k], e[k]);
      g = sb.pop_front();
      tests++;
      if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
        failed++;
        $display("FAIL lock[%0d] got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b", k,
                 ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
      end
    end
  endtask

  task automatic test_wait();
    stim_t s[$]; exp_t e[$]; exp_t g;
    s.push_back(mk(4'b1000, 1, 1, NONSEQ, SINGLE, 0)); e.push_back(ex(3, 0, 1));
    for (int k = 0; k < 5; k++) begin
      s.push_back(mk(4'b0001, 0, 1, NONSEQ, SINGLE, 0)); e.push_back(ex(3, 0, 0));
    end
    s.push_back(mk(4'b0001, 1, 1, NONSEQ, SINGLE, 0)); e.push_back(ex(0, 0, 1));
    for (int k = 0; k < s.size(); k++) begin
      drive(s[k], e[k]);
      g = sb.pop_front();
      tests++;
      if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
        failed++;
        $display("FAIL wait[%0d] got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b", k,
                 ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
      end
    end
  endtask

  task automatic test_idle_park();
    stim_t s[$]; exp_t e[$]; exp_t g;
    s.push_back(mk(4'b0000, 1, 0, IDLE, SINGLE, 0)); e.push_back(ex(0, 1, 1));
    s.push_back(mk(4'b0000, 1, 0, IDLE, SINGLE, 0)); e.push_back(ex(0, 1, 0));
    s.push_back(mk(4'b0000, 1, 1, IDLE, SINGLE, 0)); e.push_back(ex(0, 0, 1));
    s.push_back(mk(4'b0000, 1, 1, IDLE, SINGLE, 0)); e.push_back(ex(0, 0, 0));
    for (int k = 0; k < s.size(); k++) begin
      drive(s[k], e[k]);
      g = sb.pop_front();
      tests++;
      if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
        failed++;
        $display("FAIL park[%0d] got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b", k,
                 ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    stim_t s[$]; exp_t e[$]; exp_t g;
    s.push_back(mk(4'b0010, 1, 1, NONSEQ, SINGLE, 0)); e.push_back(ex(1, 0, 1));
    s.push_back(mk(4'b0000, 1, 1, NONSEQ, INCR8, 0));  e.push_back(ex(1, 0, 0));
    s.push_back(mk(4'b0100, 1, 1, SEQ, INCR8, 0));     e.push_back(ex(1, 0, 0));
    s.push_back(mk(4'b0100, 1, 1, SEQ, INCR8, 0));     e.push_back(ex(1, 0, 0));
    for (int k = 0; k < s.size(); k++) begin
      drive(s[k], e[k]);
      g = sb.pop_front();
      tests++;
      if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
        failed++;
        $display("FAIL midburst[%0d] got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b", k,
                 ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
      end
    end
    // Asynchronous reset between clock edges must take effect at once.
    @(negedge HCLK);
    HRESETn = 1'b0;
    sb.push_back(ex(0, 1, 0));
    #1;
    g = sb.pop_front();
    tests++;
    if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
      failed++;
      $display("FAIL async_reset got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b",
               ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
    end
    set_idle();
    @(negedge HCLK);
    HRESETn = 1'b1;
    s.delete(); e.delete();
    s.push_back(mk(4'b0010, 1, 1, NONSEQ, SINGLE, 0)); e.push_back(ex(1, 0, 1));
    s.push_back(mk(4'b0100, 1, 1, NONSEQ, SINGLE, 0)); e.push_back(ex(2, 0, 1));
    for (int k = 0; k < s.size(); k++) begin
      drive(s[k], e[k]);
      g = sb.pop_front();
      tests++;
      if (ifc.addr_in_port !== g.addr || ifc.no_port !== g.no || ifc.arb_switch !== g.sw) begin
        failed++;
        $display("FAIL post_reset[%0d] got addr/no/sw %0d/%0b/%0b want %0d/%0b/%0b", k,
                 ifc.addr_in_port, ifc.no_port, ifc.arb_switch, g.addr, g.no, g.sw);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr();
    test_burst();
    test_lock();
    test_wait();
    test_idle_park();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ahb_mtx_arb_rr.md
Name: ahb_mtx_arb_rr

Overview:
- Round-robin output-stage arbiter for one slave port of the sparse AHB bus matrix.
- Selects which of NUM_PORTS input stages drives the shared slave.
- Never splits a fixed-length burst or a locked sequence.
- Sits beside each output stage and drives its address/data multiplexer selects. It is the fairness-oriented alternative to the fixed-priority output arbiter, used on slaves shared by DMA and CPU masters.

Parameters:
- NUM_PORTS, 4, number of input ports connected to this output stage (2..8).
- PORT_W, 2, width of the port index; must equal ceil(log2(NUM_PORTS)), minimum 1.

Ports:
- HCLK  input  1  AHB system clock.
- HRESETn  input  1  asynchronous active-low reset.
- req_port  input  NUM_PORTS  per-input-port request; bit i = port i.
- HREADYM  input  1  transfer done on this output port.
- HSELM  input  1  slave select of the currently driven transfer.
- HTRANSM  input  2  transfer type of the currently driven transfer.
- HBURSTM  input  3  burst type of the currently driven transfer.
- HMASTLOCKM  input  1  locked transfer.
- addr_in_port  output  PORT_W  index of the granted input port (registered).
- no_port  output  1  no input port selected (registered).
- arb_switch  output  1  one-cycle pulse: grant moved to a different port or left no_port.

Behaviour:
- Reset (async, HRESETn=0) values:
  - addr_in_port=0, no_port=1, arb_switch=0.
  - burst count=0, burst hold=0.
  - rr pointer (last granted port) = NUM_PORTS-1, so port 0 wins first.
- Burst tracker (4-bit count plus registered hold flag). Update every HCLK as follows:
  - HREADYM=0: hold state.
  - HREADYM=1 and HSELM=0: clear count and hold.
  - Otherwise, by HTRANSM:
    - NONSEQ: WRAP4/INCR4 -> count 3, hold 1; WRAP8/INCR8 -> 7, hold 1; WRAP16/INCR16 -> 15, hold 1; SINGLE/INCR -> 0, hold 0.
    - SEQ: count-1; hold cleared when count==1, otherwise unchanged. A SEQ at count 0 keeps count 0 (saturates, no wrap to 15).
    - BUSY: unchanged.
    - IDLE: clear both.
  - next_hold is the combinational D-input of the hold flag.
- Candidate set (combinational): cand[i] = req_port[i] | (i==addr_in_port & !no_port & HSELM & HTRANSM!=IDLE).
- Grant decision (combinational):
  - HMASTLOCKM=1 or next_hold=1: keep current port and current no_port.
  - Else, if any cand bit is set: choose the first set bit searching (ptr+1), (ptr+2), … mod NUM_PORTS. The search includes ptr itself last. no_port_next=0.
  - Else if HSELM=1: keep current port, no_port_next=0 (park on IDLE-ing master).
  - Else: port unchanged, no_port_next=1.
- Register update: addr_in_port, no_port and ptr load only when HREADYM=1.
  - ptr <= new port whenever no_port_next=0.
  - Wait states (HREADYM=0) freeze all arbitration state, even if requests change.
- arb_switch: registered, equals HREADYM & ((no_port_next!=no_port) | (!no_port_next & new port != addr_in_port)).
- Latency: a request first visible in cycle N with HREADYM=1 and no hold is reflected on addr_in_port at cycle N+1.
- Simultaneous events:
  - Lock dominates burst hold and requests.
  - A NONSEQ fixed burst starting in the same cycle sets next_hold, so no switch occurs.
  - On the last SEQ beat (count 1 -> 0), hold clears and arbitration reopens that same cycle.
- Indices >= NUM_PORTS are never produced. Unused req_port bits do not exist (the width is exact).
- Reset mid-burst returns to the reset state immediately; no recovery of the burst context.

Test Plan:
- Reset, all req_port=0, HSELM=0 -> addr_in_port=0, no_port=1, arb_switch=0.
- NUM_PORTS=4, req_port=4'b1111 held, HSELM=1, NONSEQ SINGLE every cycle, HREADYM=1 -> grant sequence 0,1,2,3,0. arb_switch=1 on each change.
- Port 1 granted, NONSEQ INCR4 then 3 SEQ with req_port=4'b1101 -> addr_in_port stays 1 for all 4 beats. On the cycle of the 3rd SEQ the decision moves to port 2; addr_in_port=2 the following cycle.
- Port 2 granted, HMASTLOCKM=1 for 6 cycles with req_port=4'b0011 -> addr_in_port=2 throughout. It switches to port 0 (search 3,0) one cycle after lock drops.
- Port 3 granted, HREADYM=0 for 5 cycles while req_port=4'b0001 -> addr_in_port=3 frozen. addr_in_port=0 the cycle after HREADYM returns to 1.
- Port 1 granted mid-INCR8 (count 5), HRESETn pulsed low -> immediately addr_in_port=0, no_port=1. After release with req_port=4'b0010 and NONSEQ SINGLE, port 1 is granted with no burst hold.
